pipe_scoreboard: RTL and testbench

PIPE_SCOREBOARD -- requirements
Module: pipe_scoreboard

---
 rtl/pipe_scoreboard.sv | 109 ++++++++++
 tb/tb_pipe_scoreboard.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_scoreboard.sv
`default_nettype none
// ============================================================================
// pipe_scoreboard : in-order issue scoreboard tracking pending register writes
//                   and stalling ID on read-after-write hazards.
//                   Define PIPE_SCOREBOARD_FWD_EN to assume EX/MEM forwarding
//                   (only a load in EX blocks); otherwise full interlock.
// Revision: 1.0
// ============================================================================
module pipe_scoreboard #(
  parameter int REG_ADDR_WIDTH  = 3,
  parameter int NUM_RD_PORTS    = 2,
  parameter int WB_LATENCY      = 3,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic                                          issue_valid_i,
  input  logic                                          issue_wr_en_i,
  input  logic [REG_ADDR_WIDTH-1:0]                     issue_wr_addr_i,
  input  logic                                          issue_is_load_i,
  input  logic [NUM_RD_PORTS-1:0][REG_ADDR_WIDTH-1:0]   rd_addr_i,
  input  logic [NUM_RD_PORTS-1:0]                       rd_used_i,
  input  logic                                          flush_i,
  output logic                                          pipeline_ready_o,
  output logic [STALL_CNT_WIDTH-1:0]                    stall_cnt_o
);

  logic [WB_LATENCY-1:0]                      valid_q, valid_d;
  logic [WB_LATENCY-1:0][REG_ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [WB_LATENCY-1:0]                      load_q, load_d;
  logic [STALL_CNT_WIDTH-1:0]                 stall_cnt_q, stall_cnt_d;
  logic [WB_LATENCY-1:0]                      slot_qual;
  logic [NUM_RD_PORTS-1:0]                    port_hazard;
  logic                                       ready;
  logic                                       unused_sig;

  // Which slots can still block a reader (not yet visible through forwarding/RF).
  genvar s;
  generate
    for (s = 0; s < WB_LATENCY; s++) begin : g_qual
`ifdef PIPE_SCOREBOARD_FWD_EN
      if (s == 0) begin : g_ex
        assign slot_qual[s] = valid_q[s] & load_q[s];
      end else begin : g_fwd
        assign slot_qual[s] = 1'b0;
      end
`else
      assign slot_qual[s] = valid_q[s];
`endif
    end
  endgenerate

  always_comb begin
    port_hazard = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      if (rd_used_i[p] && (rd_addr_i[p] != '0)) begin
        for (int k = 0; k < WB_LATENCY; k++) begin
          if (slot_qual[k] && (addr_q[k] == rd_addr_i[p])) begin
            port_hazard[p] = 1'b1;
          end
        end
      end
    end
  end

  assign ready = ~|port_hazard;

  // Hazards above see pre-shift contents, so a flushed EX entry still blocks this cycle.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    load_d  = load_q;
    for (int k = WB_LATENCY - 1; k > 0; k--) begin
      valid_d[k] = valid_q[k-1] & ~((k == 1) & flush_i);
      addr_d[k]  = addr_q[k-1];
      load_d[k]  = load_q[k-1];
    end
    valid_d[0] = issue_valid_i & ready & issue_wr_en_i;
    addr_d[0]  = issue_wr_addr_i;
    load_d[0]  = issue_is_load_i;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (issue_valid_i && !ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
    end
    addr_q <= addr_d;
    load_q <= load_d;
  end

  assign pipeline_ready_o = ready;
  assign stall_cnt_o      = stall_cnt_q;

  // Load flags and flush are not consulted in every configuration.
  assign unused_sig = ^{load_q, flush_i};

endmodule
`default_nettype wire

// File: tb/tb_pipe_scoreboard.sv
`default_nettype none
// tb_pipe_scoreboard : directed vector table, hand sequences and randomized
// stimulus checked against a pending-write list model.
module tb_pipe_scoreboard;

  localparam int AW      = 3;
  localparam int NP      = 2;
  localparam int WB_LAT  = 3;
  localparam int SAT_MAX = 15;

  logic                   clk;
  logic                   rst;
  logic                   vld;
  logic                   wen;
  logic [AW-1:0]          wa;
  logic                   ld;
  logic [NP-1:0][AW-1:0]  ra;
  logic [NP-1:0]          used;
  logic                   fl;
  logic                   rdy;
  logic [15:0]            cnt;
  logic                   rdy_sat;
  logic [3:0]             cnt_sat;

  int n_cmp = 0;
  int n_err = 0;

  pipe_scoreboard #(
    .REG_ADDR_WIDTH(AW), .NUM_RD_PORTS(NP), .WB_LATENCY(WB_LAT), .STALL_CNT_WIDTH(16)
  ) dut (
    .clk_i(clk), .rst_i(rst), .issue_valid_i(vld), .issue_wr_en_i(wen),
    .issue_wr_addr_i(wa), .issue_is_load_i(ld), .rd_addr_i(ra), .rd_used_i(used),
    .flush_i(fl), .pipeline_ready_o(rdy), .stall_cnt_o(cnt)
  );

  pipe_scoreboard #(
    .REG_ADDR_WIDTH(AW), .NUM_RD_PORTS(NP), .WB_LATENCY(WB_LAT), .STALL_CNT_WIDTH(4)
  ) dut_sat (
    .clk_i(clk), .rst_i(rst), .issue_valid_i(vld), .issue_wr_en_i(wen),
    .issue_wr_addr_i(wa), .issue_is_load_i(ld), .rd_addr_i(ra), .rd_used_i(used),
    .flush_i(fl), .pipeline_ready_o(rdy_sat), .stall_cnt_o(cnt_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model: list of writes still in flight ----------
  typedef struct {
    logic [AW-1:0] addr;
    bit            is_ld;
    int            age;
  } pend_t;

  pend_t pq[$];
  int    mcnt = 0;

  function automatic bit blocks(pend_t e);
`ifdef PIPE_SCOREBOARD_FWD_EN
    return (e.age == 0) && e.is_ld;
`else
    return 1'b1;
`endif
  endfunction

  function automatic bit model_ready();
    for (int p = 0; p < NP; p++) begin
      if (used[p] && ra[p] != 0) begin
        foreach (pq[i]) begin
          if (blocks(pq[i]) && pq[i].addr == ra[p]) return 1'b0;
        end
      end
    end
    return 1'b1;
  endfunction

  function automatic void model_update(bit r);
    pend_t nq[$];
    pend_t e;
    if (rst) begin
      pq.delete();
      mcnt = 0;
      return;
    end
    if (vld && !r && mcnt < 65535) mcnt++;
    foreach (pq[i]) begin
      e = pq[i];
      if (!(e.age == 0 && fl)) begin
        e.age++;
        if (e.age < WB_LAT) nq.push_back(e);
      end
    end
    if (vld && r && wen) begin
      e.addr = wa; e.is_ld = ld; e.age = 0;
      nq.push_back(e);
    end
    pq = nq;
  endfunction

  // ---------------- helpers ---------------------------------------------------
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(bit r, bit v, bit w, logic [AW-1:0] a, bit l,
                       logic [AW-1:0] r0, logic [AW-1:0] r1, logic [1:0] u, bit f);
    rst = r; vld = v; wen = w; wa = a; ld = l;
    ra[0] = r0; ra[1] = r1; used = u; fl = f;
  endtask

  task automatic tick();
    bit r;
    r = model_ready();
    @(posedge clk);
    model_update(r);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    tick();
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
  endtask

  typedef struct {
    bit            v;
    bit            w;
    logic [AW-1:0] a;
    bit            l;
    logic [AW-1:0] r0;
    logic [AW-1:0] r1;
    logic [1:0]    u;
    bit            f;
    bit            exp_rdy;
    int            exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(bit v, bit w, logic [AW-1:0] a, bit l, logic [AW-1:0] r0,
                     logic [AW-1:0] r1, logic [1:0] u, bit f, bit er, int ec);
    vec_t t;
    t.v = v; t.w = w; t.a = a; t.l = l; t.r0 = r0; t.r1 = r1; t.u = u; t.f = f;
    t.exp_rdy = er; t.exp_cnt = ec;
    vecs.push_back(t);
  endtask

  initial begin
    int stalls;
    drive(1, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    @(negedge clk);
    do_reset();

    #1;
    check("reset_ready", 32'(rdy), 1);
    check("reset_cnt", 32'(cnt), 0);

    // ---------------- directed vector table ---------------------------------
`ifdef PIPE_SCOREBOARD_FWD_EN
    add(1, 1, 2, 1, 0, 0, 2'b00, 0, 1, 0);  // load r2
    add(1, 0, 0, 0, 2, 0, 2'b01, 0, 0, 0);  // load-use stall
    add(1, 0, 0, 0, 2, 0, 2'b01, 0, 1, 1);
    add(1, 1, 2, 0, 0, 0, 2'b00, 0, 1, 1);  // ALU write r2
    add(1, 0, 0, 0, 2, 0, 2'b01, 0, 1, 1);  // forwarded, no stall
    add(1, 1, 0, 1, 0, 0, 2'b00, 0, 1, 1);  // load r0
    add(1, 0, 0, 0, 0, 0, 2'b11, 0, 1, 1);
    add(1, 1, 5, 1, 0, 0, 2'b00, 0, 1, 1);  // load r5 then flush it
    add(1, 0, 0, 0, 5, 0, 2'b01, 1, 0, 1);
    add(1, 0, 0, 0, 5, 0, 2'b01, 0, 1, 2);
    add(1, 1, 6, 1, 0, 0, 2'b00, 0, 1, 2);  // load r6, port 1 reads
    add(0, 0, 0, 0, 0, 6, 2'b10, 0, 0, 2);
    add(1, 0, 0, 0, 0, 6, 2'b10, 0, 1, 2);
`else
    add(1, 1, 3, 0, 0, 0, 2'b00, 0, 1, 0);  // write r3
    add(1, 0, 0, 0, 3, 0, 2'b01, 0, 0, 0);
    add(1, 0, 0, 0, 3, 0, 2'b01, 0, 0, 1);
    add(1, 0, 0, 0, 3, 0, 2'b01, 0, 0, 2);
    add(1, 0, 0, 0, 3, 0, 2'b01, 0, 1, 3);
    add(1, 1, 0, 0, 0, 0, 2'b00, 0, 1, 3);  // write r0
    add(1, 0, 0, 0, 0, 0, 2'b11, 0, 1, 3);
    add(1, 1, 5, 0, 0, 0, 2'b00, 0, 1, 3);  // write r5, flushed next cycle
    add(1, 0, 0, 0, 5, 0, 2'b01, 1, 0, 3);
    add(1, 0, 0, 0, 5, 0, 2'b01, 0, 1, 4);
    add(1, 1, 6, 0, 0, 0, 2'b00, 0, 1, 4);  // write r6, port 1 reads
    add(0, 0, 0, 0, 0, 6, 2'b10, 0, 0, 4);
    add(1, 0, 0, 0, 0, 6, 2'b10, 0, 0, 4);
    add(1, 0, 0, 0, 0, 6, 2'b10, 0, 0, 5);
    add(1, 0, 0, 0, 0, 6, 2'b10, 0, 1, 6);
    add(1, 1, 7, 0, 0, 0, 2'b00, 0, 1, 6);  // unused port ignores r7
    add(1, 0, 0, 0, 7, 7, 2'b00, 0, 1, 6);
`endif
    foreach (vecs[i]) begin
      drive(0, vecs[i].v, vecs[i].w, vecs[i].a, vecs[i].l, vecs[i].r0, vecs[i].r1,
            vecs[i].u, vecs[i].f);
      #1;
      check($sformatf("vec%0d_ready", i), 32'(rdy), 32'(vecs[i].exp_rdy));
      check($sformatf("vec%0d_cnt", i), 32'(cnt), 32'(vecs[i].exp_cnt));
      tick();
    end

    // ---------------- reset in the middle of a stall ------------------------
    do_reset();
    drive(0, 1, 1, 4, 1, 0, 0, 2'b00, 0);
    #1; check("rstmid_issue_ready", 32'(rdy), 1);
    tick();
    drive(0, 1, 0, 0, 0, 4, 4, 2'b11, 0);
    #1; check("rstmid_stall_ready", 32'(rdy), 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rstmid_after_ready", 32'(rdy), 1);
    check("rstmid_after_cnt", 32'(cnt), 0);
    tick();

    // ---------------- saturation: continuous self-dependent issue ----------
    do_reset();
    stalls = 0;
    for (int c = 0; c < 40; c++) begin
      drive(0, 1, 1, 3, 1, 3, 3, 2'b11, 0);
      #1;
      if (!model_ready()) stalls++;
      check("sat_ready", 32'(rdy), 32'(model_ready()));
      tick();
    end
    #1;
`ifdef PIPE_SCOREBOARD_FWD_EN
    check("sat_stalls_wide", 32'(cnt), 20);
`else
    check("sat_stalls_wide", 32'(cnt), 30);
`endif
    check("sat_model_cnt", 32'(cnt), 32'(stalls));
    check("sat_cnt_4bit", 32'(cnt_sat), SAT_MAX);

    // ---------------- randomized vs. model ---------------------------------
    do_reset();
    for (int c = 0; c < 500; c++) begin
      drive(($urandom_range(0, 49) == 0), $urandom_range(0, 3) != 0, $urandom_range(0, 1),
            AW'($urandom_range(0, 7)), $urandom_range(0, 1),
            AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0));
      #1;
      check("rnd_ready", 32'(rdy), 32'(model_ready()));
      check("rnd_cnt", 32'(cnt), 32'(mcnt));
      check("rnd_cnt_sat", 32'(cnt_sat), 32'((mcnt > SAT_MAX) ? SAT_MAX : mcnt));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
